// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: state encoding, default
// word width and frame-length derivation.
// Frame length grows by one trailing parity bit when PARITY_CHECK_EN is defined.
package serial_word_assembler_pkg;

  // Frame progress: IDLE means no bits of the current frame received yet.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits per frame on the serial line for a given data width.
  function automatic int frame_len(input int width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/dff_ne_r.sv
// 1-bit falling-edge storage cell with synchronous active-low reset and load enable.
// Latency: d_i appears on q_o just after the falling edge of clk_i where en_i=1.
// No backpressure: the cell holds its value whenever en_i=0; reset overrides en_i.
module dff_ne_r (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic en_n;
  logic sel;
  logic sel_n;
  logic load_n;
  logic keep_n;
  logic mux;
  logic d_n;
  logic q_d;
  logic q_q;

  // NAND-only next-state network. sel is forced high during reset so the
  // reset value is loaded even when the enable is low.
  assign en_n   = ~(en_i & en_i);
  assign sel    = ~(en_n & rst_n_i);
  assign sel_n  = ~(sel & sel);
  assign load_n = ~(sel & d_i);
  assign keep_n = ~(sel_n & q_q);
  assign mux    = ~(load_n & keep_n);
  assign d_n    = ~(mux & rst_n_i);
  assign q_d    = ~(d_n & d_n);

  // Storage element clocked on the falling edge.
  always_ff @(negedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-in/parallel-out word assembler, MSB first; optional trailing even-parity bit (PARITY_CHECK_EN).
// Latency: PO/VALID update on the same falling edge of C that consumes the last bit of a frame.
// No backpressure: SE=0 freezes the frame in progress; VALID is a one-cycle strobe per word.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             C,
  input  logic             Rnot,
  input  logic             SI,
  input  logic             SE,
  output logic [WIDTH-1:0] PO,
  output logic             VALID,
  output logic             BUSY,
  output logic             PERR
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = $clog2(FRAME + 1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             state_bit_q;
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] po_q;
  logic [WIDTH-1:0] po_d;
  logic             valid_q;
  logic             valid_d;
  logic             last_bit;
  logic             data_bit;
  logic             sr_en;
  logic             po_en;

  assign state_q = state_t'(state_bit_q);

  // Next-state decode: shift/count on SE, publish the word on the frame's last bit.
  always_comb begin
    last_bit = 1'b0;
    data_bit = 1'b0;
    sr_en    = 1'b0;
    po_en    = 1'b0;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    valid_d  = 1'b0;

    last_bit = SE && (cnt_q == CW'(FRAME - 1));
    // With a parity bit appended, the final position is not a data bit.
    data_bit = (cnt_q < CW'(WIDTH));
    sr_en    = SE && data_bit;
    sr_d     = {sr_q[WIDTH-2:0], SI};
    cnt_d    = last_bit ? '0 : cnt_q + CW'(1);
    state_d  = last_bit ? IDLE : SHIFT;
    po_en    = last_bit;
    valid_d  = last_bit;
  end

`ifdef PARITY_CHECK_EN
  // Last bit is parity, so SR already holds the full word.
  assign po_d = sr_q;
`else
  // Last bit is data, so the current SI completes the word.
  assign po_d = sr_d;
`endif

  genvar i;

  generate
    for (i = 0; i < WIDTH; i++) begin : g_sr
      dff_ne_r u_sr (
        .clk_i  (C),
        .rst_n_i(Rnot),
        .en_i   (sr_en),
        .d_i    (sr_d[i]),
        .q_o    (sr_q[i])
      );
    end

    for (i = 0; i < CW; i++) begin : g_cnt
      dff_ne_r u_cnt (
        .clk_i  (C),
        .rst_n_i(Rnot),
        .en_i   (SE),
        .d_i    (cnt_d[i]),
        .q_o    (cnt_q[i])
      );
    end

    for (i = 0; i < WIDTH; i++) begin : g_po
      dff_ne_r u_po (
        .clk_i  (C),
        .rst_n_i(Rnot),
        .en_i   (po_en),
        .d_i    (po_d[i]),
        .q_o    (po_q[i])
      );
    end
  endgenerate

  dff_ne_r u_state (
    .clk_i  (C),
    .rst_n_i(Rnot),
    .en_i   (SE),
    .d_i    (state_d),
    .q_o    (state_bit_q)
  );

  // VALID reloads every edge so it drops back to 0 right after the strobe.
  dff_ne_r u_valid (
    .clk_i  (C),
    .rst_n_i(Rnot),
    .en_i   (1'b1),
    .d_i    (valid_d),
    .q_o    (valid_q)
  );

`ifdef PARITY_CHECK_EN
  logic perr_d;
  logic perr_q;

  // Even parity: data bits XOR parity bit is 1 on error.
  assign perr_d = (^sr_q) ^ SI;

  dff_ne_r u_perr (
    .clk_i  (C),
    .rst_n_i(Rnot),
    .en_i   (po_en),
    .d_i    (perr_d),
    .q_o    (perr_q)
  );

  assign PERR = perr_q;
`else
  // Word MSB is only ever shifted out, never read, when no parity bit exists.
  logic unused_sr_msb;
  assign unused_sr_msb = sr_q[WIDTH-1];
  assign PERR          = 1'b0;
`endif

  assign PO    = po_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q == SHIFT);

endmodule
